// File: rtl/alu_issue_stage.sv
// RV32I decode/issue stage feeding a registered ALU; owns the integer regfile.
// Optional LUI/AUIPC issue is enabled by defining ALU_ISSUE_UPPER_EN.
module alu_issue_stage #(
    parameter int XLEN      = 32,
    parameter int REG_COUNT = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [31:0]     in_pc,
    output logic            alu_i,
    output logic [XLEN-1:0] alu_op0,
    output logic [XLEN-1:0] alu_op1,
    output logic [3:0]      alu_opcode,
    input  logic [XLEN-1:0] alu_result,
    output logic            illegal,
    input  logic [4:0]      dbg_addr,
    output logic [XLEN-1:0] dbg_data
);

    localparam int AW = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1;

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;

    logic [XLEN-1:0] r_regs [REG_COUNT];

    logic            r_s1_v;
    logic [4:0]      r_s1_rd;
    logic            r_s2_v;
    logic [4:0]      r_s2_rd;

    logic [6:0]      w_major;
    logic [2:0]      w_f3;
    logic [6:0]      w_f7;
    logic [4:0]      w_rd;
    logic [4:0]      w_rs1;
    logic [4:0]      w_rs2;
    logic            w_bad_rd;
    logic            w_bad_rs1;
    logic            w_bad_rs2;
    logic [XLEN-1:0] w_imm;
    logic [XLEN-1:0] w_uimm;
    logic [XLEN-1:0] w_rs1v;
    logic [XLEN-1:0] w_rs2v;

    logic            w_legal;
    logic [3:0]      w_opc;
    logic [XLEN-1:0] w_op0;
    logic [XLEN-1:0] w_op1;
    logic            w_use1;
    logic            w_use2;
    logic            w_stall;
    logic            w_xfer;

    assign w_major = in_instr[6:0];
    assign w_f3    = in_instr[14:12];
    assign w_f7    = in_instr[31:25];
    assign w_rd    = in_instr[11:7];
    assign w_rs1   = in_instr[19:15];
    assign w_rs2   = in_instr[24:20];

    assign w_bad_rd  = int'(w_rd)  >= REG_COUNT;
    assign w_bad_rs1 = int'(w_rs1) >= REG_COUNT;
    assign w_bad_rs2 = int'(w_rs2) >= REG_COUNT;

    assign w_imm  = XLEN'($signed(in_instr[31:20]));
    assign w_uimm = XLEN'($signed({in_instr[31:12], 12'b0}));

    // Operand read with bypass from the result the ALU is presenting now
    always_comb begin
        w_rs1v = '0;
        w_rs2v = '0;
        if (w_rs1 != 5'd0 && !w_bad_rs1) begin
            if (r_s2_v && r_s2_rd == w_rs1) w_rs1v = alu_result;
            else w_rs1v = r_regs[w_rs1[AW-1:0]];
        end
        if (w_rs2 != 5'd0 && !w_bad_rs2) begin
            if (r_s2_v && r_s2_rd == w_rs2) w_rs2v = alu_result;
            else w_rs2v = r_regs[w_rs2[AW-1:0]];
        end
    end

`ifdef ALU_ISSUE_UPPER_EN
    logic [XLEN-1:0] w_pc;
    assign w_pc = XLEN'(in_pc);
`else
    logic w_unused_pc;
    assign w_unused_pc = ^in_pc;
`endif

    // Decode major opcode into ALU op, operands and source usage
    always_comb begin
        w_legal = 1'b0;
        w_opc   = 4'd0;
        w_op0   = w_rs1v;
        w_op1   = w_rs2v;
        w_use1  = 1'b0;
        w_use2  = 1'b0;
        case (w_major)
            OPC_OP: begin
                w_use1  = 1'b1;
                w_use2  = 1'b1;
                w_opc   = {w_f3, in_instr[30]};
                w_legal = !w_bad_rd && !w_bad_rs1 && !w_bad_rs2 &&
                          (w_f7 == 7'b0000000 ||
                           (w_f7 == 7'b0100000 &&
                            (w_f3 == 3'b000 || w_f3 == 3'b101)));
            end
            OPC_IMM: begin
                w_use1  = 1'b1;
                w_op1   = w_imm;
                w_opc   = {w_f3, (w_f3 == 3'b101) ? in_instr[30] : 1'b0};
                w_legal = !w_bad_rd && !w_bad_rs1;
            end
`ifdef ALU_ISSUE_UPPER_EN
            OPC_LUI: begin
                w_op0   = '0;
                w_op1   = w_uimm;
                w_legal = !w_bad_rd;
            end
            OPC_AUIPC: begin
                w_op0   = w_pc;
                w_op1   = w_uimm;
                w_legal = !w_bad_rd;
            end
`endif
            default: w_legal = 1'b0;
        endcase
    end

    assign w_stall = w_legal && r_s1_v && r_s1_rd != 5'd0 &&
                     ((w_use1 && w_rs1 == r_s1_rd) ||
                      (w_use2 && w_rs2 == r_s1_rd));

    assign in_ready = !w_stall;
    assign w_xfer   = in_valid && in_ready;

    // Issue registers toward the ALU and the illegal pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_i      <= 1'b0;
            alu_op0    <= '0;
            alu_op1    <= '0;
            alu_opcode <= 4'd0;
            illegal    <= 1'b0;
        end else begin
            alu_i   <= w_xfer && w_legal;
            illegal <= w_xfer && !w_legal;
            if (w_xfer && w_legal) begin
                alu_op0    <= w_op0;
                alu_op1    <= w_op1;
                alu_opcode <= w_opc;
            end
        end
    end

    // Destination tags for the two in-flight ALU stages
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_v  <= 1'b0;
            r_s1_rd <= 5'd0;
            r_s2_v  <= 1'b0;
            r_s2_rd <= 5'd0;
        end else begin
            r_s1_v  <= w_xfer && w_legal;
            r_s1_rd <= w_rd;
            r_s2_v  <= r_s1_v;
            r_s2_rd <= r_s1_rd;
        end
    end

    // Register file writeback from the ALU result stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < REG_COUNT; k++) r_regs[k] <= '0;
        end else if (r_s2_v && r_s2_rd != 5'd0) begin
            r_regs[r_s2_rd[AW-1:0]] <= alu_result;
        end
    end

    assign dbg_data = (dbg_addr == 5'd0 || int'(dbg_addr) >= REG_COUNT) ?
                      '0 : r_regs[dbg_addr[AW-1:0]];

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage with a registered ALU model.
// Expects the same ALU_ISSUE_UPPER_EN setting as the RTL build.
module tb_alu_issue_stage;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        alu_i;
    logic [31:0] alu_op0;
    logic [31:0] alu_op1;
    logic [3:0]  alu_opcode;
    logic [31:0] alu_result;
    logic        illegal;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_data;

    int n_cmp = 0;
    int n_bad = 0;

    alu_issue_stage #(.XLEN(32), .REG_COUNT(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc),
        .alu_i(alu_i), .alu_op0(alu_op0), .alu_op1(alu_op1),
        .alu_opcode(alu_opcode), .alu_result(alu_result),
        .illegal(illegal), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] alu_f(logic [3:0] op,
                                          logic [31:0] a,
                                          logic [31:0] b);
        case (op)
            4'b0000: return a + b;
            4'b0001: return a - b;
            4'b0010: return a << b[4:0];
            4'b0100: return {31'd0, $signed(a) < $signed(b)};
            4'b0110: return {31'd0, a < b};
            4'b1000: return a ^ b;
            4'b1010: return a >> b[4:0];
            4'b1011: return 32'($signed(a) >>> b[4:0]);
            4'b1100: return a | b;
            4'b1110: return a & b;
            default: return 32'hDEADBEEF;
        endcase
    endfunction

    // Registered ALU: samples issue outputs on the edge after alu_i
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) alu_result <= '0;
        else if (alu_i) alu_result <= alu_f(alu_opcode, alu_op0, alu_op1);
    end

    function automatic logic [31:0] rt(logic [6:0] f7, logic [4:0] rs2,
                                       logic [4:0] rs1, logic [2:0] f3,
                                       logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] it(logic [11:0] imm, logic [4:0] rs1,
                                       logic [2:0] f3, logic [4:0] rd);
        return {imm, rs1, f3, rd, 7'b0010011};
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic rchk(string name, logic [4:0] a, logic [31:0] exp);
        dbg_addr = a;
        #1;
        chk(name, dbg_data, exp);
    endtask

    // Present at negedge, transfer at posedge, return #1 after it
    task automatic issue(logic [31:0] instr);
        @(negedge clk);
        in_valid = 1'b1;
        in_instr = instr;
        #1;
        chk("ready_before_issue", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic cyc(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    typedef struct {
        string       name;
        logic [31:0] instr;
        bit          ok;
        logic [3:0]  opc;
        logic [31:0] op0;
        logic [31:0] op1;
        logic [4:0]  rd;
        logic [31:0] rdv;
    } vec_t;

    vec_t tv[$];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_instr = 32'd0;
        in_pc    = 32'h0000_1000;
        dbg_addr = 5'd0;

        tv.push_back('{"addi_x1",  it(12'd5, 5'd0, 3'b000, 5'd1),
                       1, 4'b0000, 32'd0, 32'd5, 5'd1, 32'd5});
        tv.push_back('{"addi_neg", it(12'hFFD, 5'd0, 3'b000, 5'd2),
                       1, 4'b0000, 32'd0, 32'hFFFF_FFFD, 5'd2, 32'hFFFF_FFFD});
        tv.push_back('{"addi_x6",  it(12'd1, 5'd0, 3'b000, 5'd6),
                       1, 4'b0000, 32'd0, 32'd1, 5'd6, 32'd1});
        tv.push_back('{"slli31",   it(12'd31, 5'd6, 3'b001, 5'd6),
                       1, 4'b0010, 32'd1, 32'd31, 5'd6, 32'h8000_0000});
        tv.push_back('{"add",      rt(7'h00, 5'd2, 5'd1, 3'b000, 5'd3),
                       1, 4'b0000, 32'd5, 32'hFFFF_FFFD, 5'd3, 32'd2});
        tv.push_back('{"sub",      rt(7'h20, 5'd2, 5'd1, 3'b000, 5'd9),
                       1, 4'b0001, 32'd5, 32'hFFFF_FFFD, 5'd9, 32'd8});
        tv.push_back('{"slli4",    it(12'd4, 5'd1, 3'b001, 5'd4),
                       1, 4'b0010, 32'd5, 32'd4, 5'd4, 32'h50});
        tv.push_back('{"srai",     it(12'h402, 5'd6, 3'b101, 5'd5),
                       1, 4'b1011, 32'h8000_0000, 32'h402, 5'd5, 32'hE000_0000});
        tv.push_back('{"srli",     it(12'h004, 5'd6, 3'b101, 5'd16),
                       1, 4'b1010, 32'h8000_0000, 32'd4, 5'd16, 32'h0800_0000});
        tv.push_back('{"sra_r",    rt(7'h20, 5'd4, 5'd6, 3'b101, 5'd18),
                       1, 4'b1011, 32'h8000_0000, 32'h50, 5'd18, 32'hFFFF_8000});
        tv.push_back('{"xor",      rt(7'h00, 5'd2, 5'd1, 3'b100, 5'd10),
                       1, 4'b1000, 32'd5, 32'hFFFF_FFFD, 5'd10, 32'hFFFF_FFF8});
        tv.push_back('{"sltu",     rt(7'h00, 5'd2, 5'd1, 3'b011, 5'd11),
                       1, 4'b0110, 32'd5, 32'hFFFF_FFFD, 5'd11, 32'd1});
        tv.push_back('{"slt",      rt(7'h00, 5'd2, 5'd1, 3'b010, 5'd12),
                       1, 4'b0100, 32'd5, 32'hFFFF_FFFD, 5'd12, 32'd0});
        tv.push_back('{"ori",      it(12'h010, 5'd1, 3'b110, 5'd15),
                       1, 4'b1100, 32'd5, 32'h10, 5'd15, 32'h15});
        tv.push_back('{"andi",     it(12'd6, 5'd1, 3'b111, 5'd14),
                       1, 4'b1110, 32'd5, 32'd6, 5'd14, 32'd4});
        tv.push_back('{"mul_ill",  rt(7'h01, 5'd2, 5'd1, 3'b000, 5'd13),
                       0, 4'b0000, 32'd0, 32'd0, 5'd13, 32'd0});
        tv.push_back('{"xor7_ill", rt(7'h20, 5'd2, 5'd1, 3'b100, 5'd17),
                       0, 4'b0000, 32'd0, 32'd0, 5'd17, 32'd0});
        tv.push_back('{"sw_ill",   32'h0020_A023,
                       0, 4'b0000, 32'd0, 32'd0, 5'd0, 32'd0});
        tv.push_back('{"addi_x0",  it(12'd9, 5'd0, 3'b000, 5'd0),
                       1, 4'b0000, 32'd0, 32'd9, 5'd0, 32'd0});
`ifdef ALU_ISSUE_UPPER_EN
        tv.push_back('{"lui",      32'h1234_5437,
                       1, 4'b0000, 32'd0, 32'h1234_5000, 5'd8, 32'h1234_5000});
`else
        tv.push_back('{"lui_ill",  32'h1234_5437,
                       0, 4'b0000, 32'd0, 32'd0, 5'd8, 32'd0});
`endif

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_alu_i", {31'd0, alu_i}, 32'd0);
        chk("rst_op0", alu_op0, 32'd0);
        chk("rst_op1", alu_op1, 32'd0);
        chk("rst_opcode", {28'd0, alu_opcode}, 32'd0);
        chk("rst_illegal", {31'd0, illegal}, 32'd0);
        chk("rst_ready", {31'd0, in_ready}, 32'd1);
        for (int r = 1; r < 32; r++) rchk("rst_reg", r[4:0], 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Independent vectors, spaced so nothing is in flight
        foreach (tv[i]) begin
            issue(tv[i].instr);
            chk({tv[i].name, "_alu_i"}, {31'd0, alu_i}, {31'd0, tv[i].ok});
            chk({tv[i].name, "_ill"}, {31'd0, illegal}, {31'd0, !tv[i].ok});
            if (tv[i].ok) begin
                chk({tv[i].name, "_opc"}, {28'd0, alu_opcode}, {28'd0, tv[i].opc});
                chk({tv[i].name, "_op0"}, alu_op0, tv[i].op0);
                chk({tv[i].name, "_op1"}, alu_op1, tv[i].op1);
            end
            cyc(1);
            chk({tv[i].name, "_ill_pulse"}, {31'd0, illegal}, 32'd0);
            chk({tv[i].name, "_alu_i_pulse"}, {31'd0, alu_i}, 32'd0);
            cyc(1);
            rchk({tv[i].name, "_wb"}, tv[i].rd, tv[i].rdv);
        end

        // RAW on the op issued last cycle: one bubble, then forwarded
        issue(it(12'd7, 5'd0, 3'b000, 5'd1));
        @(negedge clk);
        in_valid = 1'b1;
        in_instr = rt(7'h00, 5'd1, 5'd1, 3'b000, 5'd2);
        #1;
        chk("raw_stall", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        #1;
        chk("raw_bubble", {31'd0, alu_i}, 32'd0);
        @(negedge clk);
        #1;
        chk("raw_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("raw_alu_i", {31'd0, alu_i}, 32'd1);
        chk("raw_op0", alu_op0, 32'd7);
        chk("raw_op1", alu_op1, 32'd7);
        cyc(2);
        rchk("raw_x2", 5'd2, 32'd14);

        // x0 destination never causes a stall
        issue(it(12'd9, 5'd0, 3'b000, 5'd0));
        issue(rt(7'h00, 5'd0, 5'd0, 3'b000, 5'd7));
        chk("x0_op0", alu_op0, 32'd0);
        chk("x0_op1", alu_op1, 32'd0);
        cyc(2);
        rchk("x0_x7", 5'd7, 32'd0);
        rchk("x0_x0", 5'd0, 32'd0);

        // S1 and S2 both match: younger value wins after the bubble
        issue(it(12'd3, 5'd0, 3'b000, 5'd20));
        issue(it(12'd10, 5'd0, 3'b000, 5'd20));
        @(negedge clk);
        in_valid = 1'b1;
        in_instr = rt(7'h00, 5'd20, 5'd20, 3'b000, 5'd21);
        #1;
        chk("both_stall", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("both_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("both_op0", alu_op0, 32'd10);
        chk("both_op1", alu_op1, 32'd10);
        cyc(2);
        rchk("both_x21", 5'd21, 32'd20);
        rchk("both_x20", 5'd20, 32'd10);

        // S2 match alone forwards without stalling
        issue(it(12'd11, 5'd0, 3'b000, 5'd22));
        issue(it(12'd0, 5'd0, 3'b000, 5'd25));
        issue(rt(7'h20, 5'd0, 5'd22, 3'b000, 5'd24));
        chk("fwd_opc", {28'd0, alu_opcode}, 32'd1);
        chk("fwd_op0", alu_op0, 32'd11);
        cyc(2);
        rchk("fwd_x24", 5'd24, 32'd11);

        // Reset with an op in flight discards it
        issue(it(12'd99, 5'd0, 3'b000, 5'd26));
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_alu_i", {31'd0, alu_i}, 32'd0);
        rchk("mid_rst_x1", 5'd1, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(3);
        rchk("mid_rst_x26", 5'd26, 32'd0);
        rchk("mid_rst_x2", 5'd2, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
